bbox_detector: RTL
==================

Name: bbox_detector

Overview:
- Scans the binarised pixel stream once per frame and finds the bounding box of foreground (dark) pixels.
- Outputs the box packed as {max,min} row and column words, plus a one-cycle update strobe.
- Output format matches the rectangle overlay's iRow/iCol inputs, so this block feeds the overlay that draws the box around the detected digit.
- Sits between the gray-to-BW thresholding stage and the overlay, in the same pixel clock domain.

Parameters:
- H_ACTIVE, 640, active pixels per line; Col range 0..H_ACTIVE-1.
- V_ACTIVE, 480, active lines per frame; Row range 0..V_ACTIVE-1.
- FG_THRESH, 10'd512, pixel is foreground when GRAY2BW < FG_THRESH.
- MIN_RUN, 2, consecutive foreground pixels in one line needed before any pixel counts (noise rejection); legal range 1..15.

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, pixel valid; Row/Col/GRAY2BW are sampled only when en=1.
- Row, input, 10, current pixel row address.
- Col, input, 10, current pixel column address.
- GRAY2BW, input, 10, binarised pixel value.
- oRow, output, 20, [19:10]=max row, [9:0]=min row of the last completed frame.
- oCol, output, 20, [19:10]=max col, [9:0]=min col of the last completed frame.
- oValid, output, 1, one-cycle strobe when oRow/oCol/oFound are updated.
- oFound, output, 1, 1 when the last completed frame contained at least one qualified foreground run.

Behaviour:
- Reset (rst=1 at a clk edge):
  - oRow=0, oCol=0, oValid=0, oFound=0.
  - State=IDLE; accumulators cleared; run counter=0.
  - Reset mid-frame discards the partial frame; no oValid is issued.
- States:
  - IDLE: wait for a frame start.
  - SCAN: accumulate the box.
  - DONE: publish results for exactly one cycle.
- Frame start: en=1 with Row=0 and Col=0.
  - Entered from IDLE or DONE, go to SCAN.
  - Seen while already in SCAN, restart the frame: accumulators and run counter are re-initialised and the partial frame is discarded (no oValid).
  - The start pixel itself is processed as the first pixel of the new frame.
- Accumulator init values: minRow=1023, maxRow=0, minCol=1023, maxCol=0, hit=0.
- Pixels with Row>=V_ACTIVE or Col>=H_ACTIVE are ignored, and the run counter is not changed.
- Run counter (4-bit, saturating at MIN_RUN):
  - Col=0: counter is set to 1 if the pixel is foreground, else 0 (new line).
  - Otherwise: foreground increments the counter, background clears it.
  - en=0 holds the counter and all state (stall).
- Qualified pixel: a foreground pixel with the post-update counter >= MIN_RUN. For each qualified pixel:
  - minRow=min(minRow,Row) and maxRow=max(maxRow,Row).
  - maxCol=max(maxCol,Col).
  - minCol=min(minCol, Col-(MIN_RUN-1)) when the counter equals MIN_RUN exactly, otherwise min(minCol,Col).
  - hit=1.
  - All compares are unsigned 10-bit.
  - The subtraction cannot underflow because counter>=MIN_RUN implies Col>=MIN_RUN-1.
- Frame end: en=1 with Row=V_ACTIVE-1 and Col=H_ACTIVE-1 while in SCAN.
  - That pixel is processed, then the state goes to DONE.
- DONE (one cycle, the cycle after the frame-end pixel):
  - oValid=1 and oFound=hit.
  - If hit=1, oRow={maxRow,minRow} and oCol={maxCol,minCol}.
  - If hit=0, oRow and oCol hold their previous values.
  - The next cycle, oValid returns to 0 and the state goes to IDLE, or directly to SCAN if that cycle carries a frame start.
- Latency: results are visible one clk after the frame-end pixel is accepted.
- Outputs are registered and stable between strobes, so the overlay can sample them at any time.
- Frame end while in IDLE (no start seen): ignored, no oValid.

Test Plan:
- MIN_RUN=1, a single pixel GRAY2BW=0 at Row=100, Col=200, all others 1023 -> one oValid pulse one cycle after (479,639); oRow={10'd100,10'd100}, oCol={10'd200,10'd200}, oFound=1.
- MIN_RUN=2, a dark block in rows 50..120, cols 300..340 -> oRow={10'd120,10'd50}, oCol={10'd340,10'd300}; insert random en=0 gaps and require the same result.
- All-white frame after a valid frame -> oValid pulses, oFound=0, oRow/oCol unchanged from the previous frame.
- MIN_RUN=3:
  - Isolated 2-pixel dark runs at (10,5..6) plus a 3-pixel run at (20,30..32) -> oRow={10'd20,10'd20}, oCol={10'd32,10'd30}.
  - A dark run spanning the end of one line and the start of the next (Col=638,639 then next-row Col=0) -> not qualified.
- Frame start at Row=0, Col=0 mid-SCAN (after a dark pixel at Row 200) -> no oValid; the next complete frame reports only its own box.
- rst=1 for one cycle mid-frame -> all outputs 0 the next cycle; frame-end pixel without a subsequent frame start produces no oValid; the following full frame reports correctly.

Source files
------------

// File: rtl/bbox_detector.sv
// Bounding-box detector for the binarised pixel stream.
// Scans one frame (start at Row=0/Col=0, end at the last active pixel) and reports the
// bounding box of foreground pixels that belong to a horizontal run of at least MIN_RUN
// dark pixels. The results are registered and stay stable between update strobes.
//
// Ports:
//   clk      - pixel clock
//   rst      - synchronous active-high reset
//   en       - pixel valid; Row/Col/GRAY2BW are sampled only when en=1
//   Row/Col  - current pixel address
//   GRAY2BW  - binarised pixel value; foreground when below FG_THRESH
//   oRow     - {max row, min row} of the last completed frame
//   oCol     - {max col, min col} of the last completed frame
//   oValid   - one-cycle strobe when oRow/oCol/oFound are updated
//   oFound   - last completed frame contained at least one qualified run
module bbox_detector #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter logic [9:0]  FG_THRESH = 10'd512,
  parameter int unsigned MIN_RUN   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [9:0]  Row,
  input  logic [9:0]  Col,
  input  logic [9:0]  GRAY2BW,
  output logic [19:0] oRow,
  output logic [19:0] oCol,
  output logic        oValid,
  output logic        oFound
);

  localparam logic [3:0]  MinRun  = 4'(MIN_RUN);
  localparam logic [9:0]  RunBack = 10'(MIN_RUN - 1);
  localparam logic [9:0]  RowLast = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  ColLast = 10'(H_ACTIVE - 1);
  localparam logic [10:0] RowLim  = 11'(V_ACTIVE);
  localparam logic [10:0] ColLim  = 11'(H_ACTIVE);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  run_q, run_d;
  logic [9:0]  min_row_q, min_row_d, max_row_q, max_row_d;
  logic [9:0]  min_col_q, min_col_d, max_col_q, max_col_d;
  logic        hit_q, hit_d;
  logic [19:0] orow_q, orow_d, ocol_q, ocol_d;
  logic        ovalid_q, ovalid_d, ofound_q, ofound_d;

  logic       frame_start, frame_end, fg, in_range, process;
  logic [9:0] col_left;

  assign frame_start = en && (Row == 10'd0) && (Col == 10'd0);
  assign frame_end   = en && (Row == RowLast) && (Col == ColLast);
  assign fg          = GRAY2BW < FG_THRESH;
  assign in_range    = ({1'b0, Row} < RowLim) && ({1'b0, Col} < ColLim);

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    min_row_d = min_row_q;
    max_row_d = max_row_q;
    min_col_d = min_col_q;
    max_col_d = max_col_q;
    hit_d     = hit_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    ofound_d  = ofound_q;
    ovalid_d  = 1'b0;
    process   = 1'b0;
    col_left  = Col;

    if (frame_start) begin
      // A start pixel always opens a fresh frame, discarding any partial one.
      state_d   = StScan;
      run_d     = 4'd0;
      min_row_d = 10'h3ff;
      max_row_d = 10'd0;
      min_col_d = 10'h3ff;
      max_col_d = 10'd0;
      hit_d     = 1'b0;
      process   = 1'b1;
    end else begin
      unique case (state_q)
        StScan:  process = en;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    if (process && in_range) begin
      if (Col == 10'd0)       run_d = fg ? 4'd1 : 4'd0;
      else if (!fg)           run_d = 4'd0;
      else if (run_d < MinRun) run_d = run_d + 4'd1;

      if (fg && (run_d >= MinRun)) begin
        // On the qualifying pixel the box extends back to the start of the run.
        if (run_d == MinRun) col_left = Col - RunBack;
        if (Row < min_row_d)      min_row_d = Row;
        if (Row > max_row_d)      max_row_d = Row;
        if (Col > max_col_d)      max_col_d = Col;
        if (col_left < min_col_d) min_col_d = col_left;
        hit_d = 1'b1;
      end
    end

    if ((state_q == StScan) && frame_end && !frame_start) begin
      state_d  = StDone;
      ovalid_d = 1'b1;
      ofound_d = hit_d;
      if (hit_d) begin
        orow_d = {max_row_d, min_row_d};
        ocol_d = {max_col_d, min_col_d};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      run_q     <= 4'd0;
      min_row_q <= 10'd0;
      max_row_q <= 10'd0;
      min_col_q <= 10'd0;
      max_col_q <= 10'd0;
      hit_q     <= 1'b0;
      orow_q    <= 20'd0;
      ocol_q    <= 20'd0;
      ovalid_q  <= 1'b0;
      ofound_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      min_row_q <= min_row_d;
      max_row_q <= max_row_d;
      min_col_q <= min_col_d;
      max_col_q <= max_col_d;
      hit_q     <= hit_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      ovalid_q  <= ovalid_d;
      ofound_q  <= ofound_d;
    end
  end

  assign oRow   = orow_q;
  assign oCol   = ocol_q;
  assign oValid = ovalid_q;
  assign oFound = ofound_q;

endmodule
